// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and FSM state encoding, used by the timing receiver
// and by the display controller.
package vga_timing_pkg;

  localparam int VGA_H_PERIOD_CLK = 3200;
  localparam int VGA_V_LINES      = 525;
  localparam int VGA_TOL          = 4;
  localparam int VGA_LOCK_FRAMES  = 2;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // True when a measured line length lies within +/- tol of the nominal length.
  function automatic logic period_in_tol(input logic [11:0] period, input int nominal,
                                         input int tol);
    int diff;
    diff = int'(period) - nominal;
    return (diff <= tol) && (diff >= -tol);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous active-low sync pin, followed by a
// registered one-cycle falling-edge pulse (pulse is valid 3 clk after the pin edge).
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized level.
  logic [2:0] sync_q, sync_d;
  logic       fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
    fall_d = sync_q[2] & ~sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b111;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      fall_q <= fall_d;
    end
  end

  assign fall = fall_q;

endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers pixel/line position from raw VGA sync pulses, measures line and frame
// timing, and locks once consecutive frames match the nominal timing.
module vga_timing_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_PERIOD_CLK = VGA_H_PERIOD_CLK,
  parameter int V_LINES      = VGA_V_LINES,
  parameter int TOL          = VGA_TOL,
  parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hSync,
  input  logic        vSync,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        locked,
  output logic [11:0] line_period,
  output logic [9:0]  frame_lines,
  output logic        frame_tick,
  output logic        err
);

  localparam int TMO_LIM = 2 * H_PERIOD_CLK;
  localparam int TMO_W   = $clog2(TMO_LIM + 1);
  localparam int GC_W    = $clog2(LOCK_FRAMES + 1);

  logic hfall, vfall;

  sync_edge_detect u_hsync (.clk(clk), .rst_n(rst_n), .din(hSync), .fall(hfall));
  sync_edge_detect u_vsync (.clk(clk), .rst_n(rst_n), .din(vSync), .fall(vfall));

  logic [1:0]       state_q, state_d;
  logic [GC_W-1:0]  good_cnt_q, good_cnt_d;
  logic [11:0]      period_q, period_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [9:0]       vcount_q, vcount_d;
  logic [11:0]      line_period_q, line_period_d;
  logic [9:0]       frame_lines_q, frame_lines_d;
  logic             bad_seen_q, bad_seen_d;
  logic             locked_q, locked_d;
  logic             frame_tick_q, frame_tick_d;
  logic             err_q, err_d;

  logic [11:0]     period_inc;
  logic [9:0]      vcount_inc, lines_closing;
  logic [GC_W-1:0] good_cnt_inc;
  logic            line_bad, frame_good, timeout;

  // Line length counts the hfall cycle too, so a 3200-clk line measures 3200.
  assign period_inc    = (period_q == 12'hFFF) ? period_q : period_q + 12'd1;
  assign vcount_inc    = (vcount_q == 10'h3FF) ? vcount_q : vcount_q + 10'd1;
  assign line_bad      = hfall && !period_in_tol(period_inc, H_PERIOD_CLK, TOL);
  // A line ending on the frame edge still belongs to the frame that is closing.
  assign lines_closing = hfall ? vcount_inc : vcount_q;
  assign frame_good    = !bad_seen_q && !line_bad && (lines_closing == 10'(V_LINES));
  // The 12-bit period counter cannot reach 2 lines, so a wider counter tracks timeout.
  assign timeout       = (tmo_q == TMO_W'(TMO_LIM));
  assign good_cnt_inc  = good_cnt_q + GC_W'(1);

  always_comb begin
    period_d      = hfall ? 12'd0 : period_inc;
    tmo_d         = hfall ? '0 : (timeout ? tmo_q : tmo_q + TMO_W'(1));
    line_period_d = hfall ? period_inc : line_period_q;
    vcount_d      = vfall ? 10'd0 : lines_closing;
    frame_lines_d = vfall ? lines_closing : frame_lines_q;
    bad_seen_d    = vfall ? 1'b0 : (bad_seen_q | line_bad);
    frame_tick_d  = vfall;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vfall) begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (timeout) begin
          state_d    = ST_SEARCH;
          good_cnt_d = '0;
        end else if (vfall) begin
          if (!frame_good) begin
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_inc;
            if (good_cnt_inc == GC_W'(LOCK_FRAMES)) state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (timeout || line_bad || (vfall && !frame_good)) begin
          state_d = ST_SEARCH;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
    locked_d = (state_q == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      period_q      <= '0;
      tmo_q         <= '0;
      vcount_q      <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      bad_seen_q    <= 1'b0;
      locked_q      <= 1'b0;
      frame_tick_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      period_q      <= period_d;
      tmo_q         <= tmo_d;
      vcount_q      <= vcount_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
      bad_seen_q    <= bad_seen_d;
      locked_q      <= locked_d;
      frame_tick_q  <= frame_tick_d;
      err_q         <= err_d;
    end
  end

  assign hCount      = period_q[11:2];
  assign vCount      = vcount_q;
  assign locked      = locked_q;
  assign line_period = line_period_q;
  assign frame_lines = frame_lines_q;
  assign frame_tick  = frame_tick_q;
  assign err         = err_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver using a scaled-down timing (80-clk lines,
// 10-line frames); frame line counts are checked through a scoreboard on frame_tick.
module tb_vga_timing_receiver;

  localparam int H      = 80;
  localparam int V      = 10;
  localparam int TOL    = 2;
  localparam int LF     = 2;
  localparam int HS_LEN = 8;

  logic        clk = 1'b0;
  logic        rst_n, hSync, vSync;
  logic [9:0]  hCount, vCount, frame_lines;
  logic [11:0] line_period;
  logic        locked, frame_tick, err;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_fail    = 0;
  int err_cnt   = 0;
  int lines_cnt = 0;
  int sb_q[$];

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .H_PERIOD_CLK(H),
    .V_LINES(V),
    .TOL(TOL),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hSync(hSync),
    .vSync(vSync),
    .hCount(hCount),
    .vCount(vCount),
    .locked(locked),
    .line_period(line_period),
    .frame_lines(frame_lines),
    .frame_tick(frame_tick),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected frame_lines is the line count closed by this vsync fall.
  task automatic begin_line(input logic vs);
    @(negedge clk);
    if (!vs && vSync) begin
      sb_q.push_back(lines_cnt + 1);
      lines_cnt = 0;
    end else begin
      lines_cnt++;
    end
    hSync = 1'b0;
    vSync = vs;
  endtask

  task automatic end_line(input int len, input int spent);
    repeat (HS_LEN - spent) @(negedge clk);
    hSync = 1'b1;
    repeat (len - HS_LEN - 1) @(negedge clk);
  endtask

  task automatic drive_line(input int len, input logic vs);
    begin_line(vs);
    end_line(len, 0);
  endtask

  task automatic drive_frame(input int n, input int odd_idx, input int odd_len);
    for (int i = 0; i < n; i++)
      drive_line((i == odd_idx) ? odd_len : H, (i < 2) ? 1'b0 : 1'b1);
  endtask

  always @(negedge clk) begin
    if (rst_n && err) err_cnt++;
    if (rst_n && frame_tick) begin
      if (sb_q.size() == 0) begin
        check("frame_tick_unexpected", 32'(frame_tick), 32'd0);
      end else begin
        int exp_lines;
        exp_lines = sb_q.pop_front();
        check("frame_lines", 32'(frame_lines), exp_lines);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    hSync = 1'b1;
    vSync = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hcount", 32'(hCount), 32'd0);
    check("rst_vcount", 32'(vCount), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_line_period", 32'(line_period), 32'd0);
    check("rst_frame_lines", 32'(frame_lines), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Nominal acquisition: lock follows the third vsync fall.
    drive_frame(V, -1, H);
    drive_frame(V, -1, H);
    check("locked_before_3rd_vfall", 32'(locked), 32'd0);
    begin_line(1'b0);
    repeat (3) @(negedge clk);
    check("locked_at_vfall", 32'(locked), 32'd0);
    repeat (2) @(negedge clk);
    check("locked_rise", 32'(locked), 32'd1);
    end_line(H, 5);
    for (int i = 1; i < V; i++) drive_line(H, (i < 2) ? 1'b0 : 1'b1);
    check("line_period_nominal", 32'(line_period), H);
    check("vcount_frame_end", 32'(vCount), V - 1);
    check("hcount_line_end", 32'(hCount), (H - 5) / 4);

    // Lines at the tolerance limit keep lock.
    drive_frame(V, V - 2, H + TOL);
    check("line_period_plus_tol", 32'(line_period), H + TOL);
    check("locked_plus_tol", 32'(locked), 32'd1);
    drive_frame(V, V - 2, H - TOL);
    check("line_period_minus_tol", 32'(line_period), H - TOL);
    check("locked_minus_tol", 32'(locked), 32'd1);
    check("err_none_in_tol", err_cnt, 32'd0);

    // One line just outside tolerance drops lock; relock needs two good frames.
    drive_frame(V, V - 2, H + TOL + 1);
    check("err_bad_line", err_cnt, 32'd1);
    check("locked_bad_line", 32'(locked), 32'd0);
    check("line_period_bad", 32'(line_period), H + TOL + 1);
    drive_frame(V, -1, H);
    drive_frame(V, -1, H);
    check("locked_relock_pending", 32'(locked), 32'd0);
    drive_frame(V, -1, H);
    check("locked_relock", 32'(locked), 32'd1);

    // Short frame drops lock at the following vsync fall.
    drive_frame(V - 1, -1, H);
    drive_line(H, 1'b0);
    check("err_short_frame", err_cnt, 32'd2);
    check("locked_short_frame", 32'(locked), 32'd0);
    check("frame_lines_short", 32'(frame_lines), V - 1);
    for (int i = 1; i < V; i++) drive_line(H, (i < 2) ? 1'b0 : 1'b1);
    drive_frame(V, -1, H);
    drive_frame(V, -1, H);
    check("locked_after_short_pending", 32'(locked), 32'd0);
    drive_frame(V, -1, H);
    check("locked_after_short", 32'(locked), 32'd1);

    // Lost hsync: single timeout error and hCount saturation.
    repeat (4200) @(negedge clk);
    check("err_timeout_once", err_cnt, 32'd3);
    check("locked_timeout", 32'(locked), 32'd0);
    check("hcount_saturated", 32'(hCount), 32'd1023);
    drive_line(H, 1'b1);
    check("line_period_saturated", 32'(line_period), 32'd4095);

    // Relock, then pulse reset in the middle of a line.
    drive_frame(V, -1, H);
    drive_frame(V, -1, H);
    drive_line(H, 1'b0);
    begin_line(1'b0);
    repeat (HS_LEN) @(negedge clk);
    hSync = 1'b1;
    repeat (12) @(negedge clk);
    check("locked_before_reset", 32'(locked), 32'd1);
    check("vcount_before_reset", 32'(vCount), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_hcount", 32'(hCount), 32'd0);
    check("midrst_vcount", 32'(vCount), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_line_period", 32'(line_period), 32'd0);
    check("midrst_frame_lines", 32'(frame_lines), 32'd0);
    check("midrst_frame_tick", 32'(frame_tick), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    sb_q.delete();
    lines_cnt = 0;
    hSync = 1'b1;
    vSync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Coincident hsync/vsync fall after reset: line closes, then vCount clears.
    drive_line(H, 1'b1);
    drive_line(H, 1'b1);
    begin_line(1'b0);
    repeat (3) @(negedge clk);
    check("coinc_tick_before", 32'(frame_tick), 32'd0);
    check("coinc_vcount_before", 32'(vCount), 32'd2);
    @(negedge clk);
    check("coinc_tick", 32'(frame_tick), 32'd1);
    check("coinc_vcount_clear", 32'(vCount), 32'd0);
    check("coinc_frame_lines", 32'(frame_lines), 32'd3);
    @(negedge clk);
    check("coinc_tick_after", 32'(frame_tick), 32'd0);
    end_line(H, 5);
    for (int i = 1; i < V; i++) drive_line(H, (i < 2) ? 1'b0 : 1'b1);
    drive_frame(V, -1, H);
    check("post_reset_no_early_lock", 32'(locked), 32'd0);
    drive_frame(V, -1, H);
    check("post_reset_lock", 32'(locked), 32'd1);
    check("err_total", err_cnt, 32'd3);

    repeat (10) @(negedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
